// File: rtl/ysyx_22050058_mdu_ctrl_pkg.sv
// Shared definitions for the RV64M multiply/divide sequencer:
// op-code encodings, FSM state encodings and stall request levels.
package ysyx_22050058_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_MUL    = 4'd0,
        MDU_MULH   = 4'd1,
        MDU_MULHSU = 4'd2,
        MDU_MULHU  = 4'd3,
        MDU_DIV    = 4'd4,
        MDU_DIVU   = 4'd5,
        MDU_REM    = 4'd6,
        MDU_REMU   = 4'd7,
        MDU_MULW   = 4'd8,
        MDU_DIVW   = 4'd9,
        MDU_DIVUW  = 4'd10,
        MDU_REMW   = 4'd11,
        MDU_REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

endpackage

// File: rtl/ysyx_22050058_mdu_ctrl_step.sv
// One bit-serial iteration on the {hi,lo} accumulator pair.
// Multiply: shift-add, lo holds the multiplier, hi collects partial sums.
// Divide: restoring shift-subtract, lo holds dividend/quotient, hi the remainder.
module ysyx_22050058_mdu_ctrl_step #(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opd,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    logic          ge;

    // Single combinational step; the carry of the add is kept as the new top bit.
    always_comb begin
        sum    = {1'b0, hi} + {1'b0, opd};
        sh     = {hi, lo[XLEN-1]};
        ge     = (sh >= {1'b0, opd});
        diff   = sh - {1'b0, opd};
        hi_nxt = hi;
        lo_nxt = lo;
        if (is_div) begin
            hi_nxt = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else if (lo[0]) begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end else begin
            hi_nxt = {1'b0, hi[XLEN-1:1]};
            lo_nxt = {hi[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_22050058_mdu_ctrl.sv
// Multi-cycle RV64M multiply/divide sequencer.
// Handshake: an op is taken in IDLE when mdu_valid_i & ~mdu_flush_i; the result
// is offered with mdu_rvalid_o and held until mdu_ready_i; EX keeps inputs stable
// while mdu_stall_o is high; a flush drops any op in any state.
// Optional build macro YSYX_22050058_MDU_FASTPATH_EN finishes div-by-zero,
// signed overflow and zero-operand multiplies in one cycle.
module ysyx_22050058_mdu_ctrl
    import ysyx_22050058_mdu_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mdu_valid_i,
    input  logic [3:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_op1_i,
    input  logic [XLEN-1:0] mdu_op2_i,
    input  logic            mdu_flush_i,
    input  logic            mdu_ready_i,
    output logic            mdu_stall_o,
    output logic            mdu_rvalid_o,
    output logic [XLEN-1:0] mdu_result_o,
    output logic            mdu_busy_o,
    output mdu_state_e      mdu_state_o
);

    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] r, input logic w);
        return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q, lo_q, opd_q, a_q, result_q;
    logic             is_w_q, is_div_q, is_rem_q, is_hi_q, neg_q, neg_rem_q, dz_q;

    logic             is_w, is_div, is_rem, is_hi, s1, s2, zext, neg_a, neg_b, div_zero;
    logic [XLEN-1:0]  a, b, mag_a, mag_b, hi_n, lo_n, corr, fast_res, q, rm;
    logic [2*XLEN-1:0] prod;
    logic             accept, fast_hit;

    // Decode the incoming op and prepare signed magnitudes of both operands.
    always_comb begin
        is_w   = mdu_op_i inside {MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
        is_div = mdu_op_i inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
                                  MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW};
        is_rem = mdu_op_i inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
        is_hi  = mdu_op_i inside {MDU_MULH, MDU_MULHSU, MDU_MULHU};
        s1     = mdu_op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM,
                                  MDU_MULW, MDU_DIVW, MDU_REMW};
        s2     = mdu_op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM,
                                  MDU_MULW, MDU_DIVW, MDU_REMW};
        zext   = mdu_op_i inside {MDU_DIVUW, MDU_REMUW};
        a      = mdu_op1_i;
        b      = mdu_op2_i;
        if (is_w) begin
            a = {{(XLEN-32){mdu_op1_i[31] & ~zext}}, mdu_op1_i[31:0]};
            b = {{(XLEN-32){mdu_op2_i[31] & ~zext}}, mdu_op2_i[31:0]};
        end
        neg_a    = s1 & a[XLEN-1];
        neg_b    = s2 & b[XLEN-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
        div_zero = is_div & (b == '0);
    end

`ifdef YSYX_22050058_MDU_FASTPATH_EN
    logic            ovf, mul_zero;
    logic [XLEN-1:0] spec_r;
    // Early detection of results that need no iteration.
    always_comb begin
        ovf      = is_div & s1 & (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                                       : (a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
        mul_zero = ~is_div & ((a == '0) | (b == '0));
        spec_r   = '0;
        if (div_zero)  spec_r = is_rem ? a : '1;
        else if (ovf)  spec_r = is_rem ? '0 : a;
        fast_hit = div_zero | ovf | mul_zero;
        fast_res = fin(spec_r, is_w);
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    assign accept = (state_q == MDU_IDLE) & mdu_valid_i & ~mdu_flush_i;

    ysyx_22050058_mdu_ctrl_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .opd    (opd_q),
        .hi_nxt (hi_n),
        .lo_nxt (lo_n)
    );

    // Sign fix-up of the final iteration, with the divide-by-zero override.
    always_comb begin
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        q    = neg_q ? -lo_n : lo_n;
        rm   = neg_rem_q ? -hi_n : hi_n;
        if (is_div_q) corr = dz_q ? (is_rem_q ? a_q : '1) : (is_rem_q ? rm : q);
        else          corr = is_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= MDU_IDLE;
        else        state_q <= state_d;
    end

    // Next state and stall request; flush overrides every transition.
    always_comb begin
        state_d     = state_q;
        mdu_stall_o = STALL_DISABLE;
        case (state_q)
            MDU_IDLE: begin
                if (mdu_valid_i) mdu_stall_o = STALL_ENABLE;
                if (accept)      state_d = fast_hit ? MDU_DONE : MDU_BUSY;
            end
            MDU_BUSY: begin
                mdu_stall_o = STALL_ENABLE;
                if (cnt_q == '0) state_d = MDU_DONE;
            end
            MDU_DONE: begin
                mdu_stall_o = ~mdu_ready_i;
                if (mdu_ready_i) state_d = MDU_IDLE;
            end
            default: state_d = MDU_IDLE;
        endcase
        if (mdu_flush_i) state_d = MDU_IDLE;
    end

    // Operand latch, iteration accumulators, counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0; hi_q <= '0; lo_q <= '0; opd_q <= '0; a_q <= '0; result_q <= '0;
            is_w_q <= 1'b0; is_div_q <= 1'b0; is_rem_q <= 1'b0; is_hi_q <= 1'b0;
            neg_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0;
        end else if (accept) begin
            cnt_q     <= CNT_W'(XLEN - 1);
            hi_q      <= '0;
            lo_q      <= mag_a;
            opd_q     <= mag_b;
            a_q       <= a;
            is_w_q    <= is_w;
            is_div_q  <= is_div;
            is_rem_q  <= is_rem;
            is_hi_q   <= is_hi;
            neg_q     <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            dz_q      <= div_zero;
            if (fast_hit) result_q <= fast_res;
        end else if (state_q == MDU_BUSY && !mdu_flush_i) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) result_q <= fin(corr, is_w_q);
        end
    end

    assign mdu_rvalid_o = (state_q == MDU_DONE);
    assign mdu_busy_o   = (state_q != MDU_IDLE);
    assign mdu_result_o = result_q;
    assign mdu_state_o  = state_q;

endmodule
